// File: rtl/data_sramlike_bridge.sv
// MEM-stage to SRAM-like data bus bridge: two-phase request/data handshake,
// store lane replication, load lane extraction with sign/zero extension.
module data_sramlike_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        ext_stall,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        addr_err,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic        lat_wr, lat_sign;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr, lat_wdata;
  logic [31:0] rbuf;
  logic [31:0] wdata_rep;
  logic [31:0] load_val;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        start, capture;

  always_comb begin
    addr_err = 1'b0;
    if (mem_req) begin
      case (mem_size)
        2'd1:    addr_err = mem_addr[0];
        2'd2:    addr_err = (mem_addr[1:0] != 2'b00);
        2'd3:    addr_err = 1'b1;
        default: addr_err = 1'b0;
      endcase
    end
  end

  assign start     = mem_req & ~addr_err;
  assign mem_stall = start & (state != DONE);
  assign capture   = (state == WAIT) & data_data_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    data_req  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ: begin
        data_req = 1'b1;
        if (data_addr_ok) state_nxt = WAIT;
      end
      WAIT: if (data_data_ok) state_nxt = DONE;
      DONE: if (!ext_stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (mem_size)
      2'd0:    wdata_rep = {4{mem_wdata[7:0]}};
      2'd1:    wdata_rep = {2{mem_wdata[15:0]}};
      default: wdata_rep = mem_wdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_wr    <= 1'b0;
      lat_sign  <= 1'b0;
      lat_size  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == IDLE && start) begin
      lat_wr    <= mem_wr;
      lat_sign  <= mem_sign;
      lat_size  <= mem_size;
      lat_addr  <= mem_addr;
      lat_wdata <= wdata_rep;
    end
  end

  always_comb begin
    case (lat_addr[1:0])
      2'd0:    byte_lane = data_rdata[7:0];
      2'd1:    byte_lane = data_rdata[15:8];
      2'd2:    byte_lane = data_rdata[23:16];
      default: byte_lane = data_rdata[31:24];
    endcase
    half_lane = lat_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (lat_size)
      2'd0:    load_val = {{24{lat_sign & byte_lane[7]}}, byte_lane};
      2'd1:    load_val = {{16{lat_sign & half_lane[15]}}, half_lane};
      default: load_val = data_rdata;
    endcase
  end

  // The buffer holds the already-extended result so mem_rdata stays stable
  // even after the next access re-latches the address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rbuf <= '0;
    else if (capture) rbuf <= load_val;
  end

  assign mem_rdata  = rbuf;
  assign data_wr    = lat_wr;
  assign data_size  = lat_size;
  assign data_addr  = lat_addr;
  assign data_wdata = lat_wdata;

endmodule

// File: tb/tb_data_sramlike_bridge.sv
// Self-checking bench for data_sramlike_bridge: directed scenarios plus
// randomized accesses against an arithmetic reference model.
module tb_data_sramlike_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_wr, mem_sign, ext_stall;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stall, addr_err;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_sramlike_bridge dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_sign(mem_sign),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .ext_stall(ext_stall),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .addr_err(addr_err),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
  );

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [1:0] size, input logic sign);
    logic [31:0] v;
    int unsigned sh;
    case (size)
      2'd0: begin
        sh = (addr % 4) * 8;
        v = (word >> sh) & 32'hFF;
        if (sign && v >= 32'h80) v = v | 32'hFFFFFF00;
      end
      2'd1: begin
        sh = ((addr / 2) % 2) * 16;
        v = (word >> sh) & 32'hFFFF;
        if (sign && v >= 32'h8000) v = v | 32'hFFFF0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] wdata, input logic [1:0] size);
    case (size)
      2'd0:    return (wdata & 32'hFF) * 32'h01010101;
      2'd1:    return (wdata & 32'hFFFF) * 32'h00010001;
      default: return wdata;
    endcase
  endfunction

  function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
           (size == 2'd2 && (addr % 4) != 0);
  endfunction

  // Drives one access from IDLE through DONE exit; leaves mem_req high in IDLE.
  task automatic do_access(input logic wr, input logic [1:0] size, input logic sign,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int unsigned a_dly,
                           input int unsigned d_dly, input int unsigned ext_n,
                           input string tag);
    int unsigned stalls = 0, reqs = 0, rc = 0, wc = 0;
    int phase = 0;
    bit first = 1'b1;
    logic [31:0] exp, held;
    mem_req = 1'b1; mem_wr = wr; mem_size = size; mem_sign = sign;
    mem_addr = addr; mem_wdata = wdata; ext_stall = (ext_n > 0);
    #1;
    checks++;
    if (mem_stall !== 1'b1 || data_req !== 1'b0 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_entry: stall=%b req=%b err=%b required 1 0 0", tag, mem_stall, data_req, addr_err);
    end
    for (int cyc = 0; cyc < 60 && mem_stall === 1'b1; cyc++) begin
      stalls++;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
      if (data_req === 1'b1) begin
        reqs++;
        if (first) begin
          first = 1'b0;
          checks++;
          exp = ref_store(wdata, size);
          if (data_wr !== wr || data_size !== size || data_addr !== addr ||
              (wr && data_wdata !== exp)) begin
            errors++;
            $display("FAIL %s bus_fields: wr=%b size=%0d addr=%h wdata=%h required %b %0d %h %h",
                     tag, data_wr, data_size, data_addr, data_wdata, wr, size, addr, exp);
          end
        end
        if (rc == a_dly) begin data_addr_ok = 1'b1; phase = 1; end
        else rc++;
        if ($urandom_range(0, 1) == 1) data_data_ok = 1'b1;
      end else if (phase == 1) begin
        if (wc == d_dly) begin data_data_ok = 1'b1; data_rdata = rdata; phase = 2; end
        else wc++;
      end
      @(posedge clk); #1;
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
    checks++;
    if (stalls != 3 + a_dly + d_dly) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d required %0d", tag, stalls, 3 + a_dly + d_dly);
    end
    checks++;
    if (reqs != 1 + a_dly) begin
      errors++;
      $display("FAIL %s req_cycles: got %0d required %0d", tag, reqs, 1 + a_dly);
    end
    if (!wr) begin
      exp = ref_load(rdata, addr, size, sign);
      checks++;
      if (mem_rdata !== exp) begin
        errors++;
        $display("FAIL %s load_data: got %h required %h", tag, mem_rdata, exp);
      end
    end
    held = mem_rdata;
    for (int i = 0; i < int'(ext_n); i++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_stall !== 1'b0 || data_req !== 1'b0 || mem_rdata !== held) begin
        errors++;
        $display("FAIL %s ext_hold: stall=%b req=%b rdata=%h required 0 0 %h", tag, mem_stall, data_req, mem_rdata, held);
      end
    end
    ext_stall = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_stall !== 1'b1 || data_req !== 1'b0) begin
      errors++;
      $display("FAIL %s done_exit: stall=%b req=%b required 1 0", tag, mem_stall, data_req);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_req = 1'b0; mem_wr = 1'b0; mem_size = '0; mem_sign = 1'b0;
    mem_addr = '0; mem_wdata = '0; ext_stall = 1'b0;
    data_rdata = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #1;
    checks++;
    if (data_req !== 1'b0 || data_wr !== 1'b0 || data_size !== 2'd0 || data_addr !== 32'h0 ||
        data_wdata !== 32'h0 || mem_rdata !== 32'h0 || mem_stall !== 1'b0 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: req=%b wr=%b size=%0d addr=%h wdata=%h rdata=%h stall=%b err=%b required all 0",
               data_req, data_wr, data_size, data_addr, data_wdata, mem_rdata, mem_stall, addr_err);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_misaligned;
    logic [1:0]  sz [6] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd0};
    logic [31:0] ad [6] = '{32'h1002, 32'h1001, 32'h1000, 32'h1001, 32'h1002, 32'h1003};
    for (int i = 0; i < 6; i++) begin
      mem_req = 1'b1; mem_wr = 1'b0; mem_size = sz[i]; mem_addr = ad[i];
      #1;
      checks++;
      if (addr_err !== ref_err(sz[i], ad[i]) || mem_stall !== !ref_err(sz[i], ad[i])) begin
        errors++;
        $display("FAIL misaligned_%0d: err=%b stall=%b required %b %b", i, addr_err, mem_stall,
                 ref_err(sz[i], ad[i]), !ref_err(sz[i], ad[i]));
      end
      if (ref_err(sz[i], ad[i])) begin
        @(posedge clk); #1;
        checks++;
        if (data_req !== 1'b0) begin
          errors++;
          $display("FAIL misaligned_req_%0d: data_req=%b required 0", i, data_req);
        end
      end
      mem_req = 1'b0;
      #1;
      checks++;
      if (addr_err !== 1'b0) begin
        errors++;
        $display("FAIL err_unqualified_%0d: err=%b required 0", i, addr_err);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid;
    mem_req = 1'b1; mem_wr = 1'b0; mem_size = 2'd2; mem_sign = 1'b0; mem_addr = 32'h4000;
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; mem_req = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (data_req !== 1'b0 || mem_rdata !== 32'h0 || data_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: req=%b rdata=%h addr=%h required 0 0 0", data_req, mem_rdata, data_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    checks++;
    if (mem_rdata !== 32'h0 || data_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL stale_data_ok: rdata=%h req=%b stall=%b required 0 0 0", mem_rdata, data_req, mem_stall);
    end
  endtask

  task automatic test_flush;
    mem_req = 1'b1; mem_wr = 1'b0; mem_size = 2'd2; mem_sign = 1'b0; mem_addr = 32'h3000;
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; mem_req = 1'b0;
    #1;
    checks++;
    if (mem_stall !== 1'b0 || data_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: stall=%b req=%b required 0 0", mem_stall, data_req);
    end
    data_data_ok = 1'b1; data_rdata = 32'h0BADC0DE;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_rdata !== 32'h0BADC0DE || data_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_complete: rdata=%h req=%b required 0badc0de 0", mem_rdata, data_req);
    end
  endtask

  task automatic test_random;
    logic [1:0]  size;
    logic [31:0] addr;
    for (int i = 0; i < 20; i++) begin
      size = 2'($urandom_range(0, 2));
      addr = $urandom;
      if (size == 2'd1) addr[0] = 1'b0;
      if (size == 2'd2) addr[1:0] = 2'b00;
      do_access(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom, $urandom,
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), "random");
    end
    mem_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    do_access(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0, 0, "word_load");
    do_access(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80123456, 0, 0, 0, "byte_load_signed");
    do_access(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80123456, 1, 2, 0, "byte_load_unsigned");
    do_access(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000ABCD, 32'h0, 0, 1, 0, "half_store");
    mem_req = 1'b0;
    @(posedge clk); #1;
    test_misaligned();
    do_access(1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, 32'h12345678, 0, 0, 3, "ext_stall_done");
    test_reset_mid();
    do_access(1'b0, 2'd1, 1'b1, 32'h5002, 32'h0, 32'h8001_7FFF, 0, 0, 0, "after_reset");
    mem_req = 1'b0;
    @(posedge clk); #1;
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
